// File: rtl/aes_spi_pkg.sv
// rtl/aes_spi_pkg.sv - shared constants, FSM state type and counter sizing for the AES SPI slave
package aes_spi_pkg;

  localparam int NK_MIN = 4;
  localparam int NK_MAX = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with registered rise/fall strobes
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Chain resets low so a low pin at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  // prev is aligned with the strobes, so consumers see data and edge in the same cycle.
  assign level = prev;

endmodule

// File: rtl/aes_spi_slave.sv
// rtl/aes_spi_slave.sv - SPI mode-0 slave moving NK*32-bit AES frames; frame_err built with AES_SPI_FRAME_ERR_EN
module aes_spi_slave
  import aes_spi_pkg::*;
#(
  parameter int NK          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [NK*32-1:0] rx_data,
  output logic             rx_valid,
  input  logic [NK*32-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_pending
`ifdef AES_SPI_FRAME_ERR_EN
  , output logic           frame_err
`endif
);

  localparam int W  = NK * 32;
  localparam int CW = cnt_width(W);

  if (NK < NK_MIN || NK > NK_MAX || (NK % 2) != 0 || SYNC_STAGES < 2) begin : g_bad_param
    $error("aes_spi_slave: unsupported NK or SYNC_STAGES");
  end

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  shift_in;
  logic [W-1:0]  shift_out;
  logic [W-1:0]  tx_buf;
`ifdef AES_SPI_FRAME_ERR_EN
  logic          overrun_seen;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      tx_buf     <= '0;
      tx_pending <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
`ifdef AES_SPI_FRAME_ERR_EN
      frame_err    <= 1'b0;
      overrun_seen <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef AES_SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (tx_load) begin
        tx_buf     <= tx_data;
        tx_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state      <= ACTIVE;
            cnt        <= '0;
            shift_in   <= '0;
            // A load coinciding with frame start bypasses the buffer entirely.
            shift_out  <= tx_load ? tx_data : (tx_pending ? tx_buf : '0);
            tx_pending <= 1'b0;
`ifdef AES_SPI_FRAME_ERR_EN
            overrun_seen <= 1'b0;
`endif
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            state <= IDLE;
`ifdef AES_SPI_FRAME_ERR_EN
            frame_err <= 1'b1;
`endif
          end else begin
            if (sck_rise) begin
              shift_in <= {shift_in[W-2:0], mosi_s};
              cnt      <= cnt + CW'(1);
              if (cnt == CW'(W - 1)) begin
                rx_data  <= {shift_in[W-2:0], mosi_s};
                rx_valid <= 1'b1;
                state    <= DONE;
              end
            end
            if (sck_fall) begin
              shift_out <= {shift_out[W-2:0], 1'b0};
            end
          end
        end

        DONE: begin
          if (cs_rise) begin
            state <= IDLE;
          end
`ifdef AES_SPI_FRAME_ERR_EN
          else if (sck_rise && !overrun_seen) begin
            overrun_seen <= 1'b1;
            frame_err    <= 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign miso = (state != IDLE) & shift_out[W-1];

endmodule

// File: tb/tb_aes_spi_slave.sv
// tb/tb_aes_spi_slave.sv - directed bench for aes_spi_slave at NK=4 and NK=8 sharing the SPI pins
module tb_aes_spi_slave;

  localparam int SS   = 2;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso4, miso8;
  logic [127:0] rx_data4;
  logic [255:0] rx_data8;
  logic         rx_valid4, rx_valid8;
  logic [127:0] tx_data4 = '0;
  logic [255:0] tx_data8 = '0;
  logic         tx_load4 = 1'b0, tx_load8 = 1'b0;
  logic         tx_pending4, tx_pending8;
`ifdef AES_SPI_FRAME_ERR_EN
  logic         frame_err4, frame_err8;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nvalid4 = 0, nvalid8 = 0, nferr4 = 0;
  int valid_cyc4 = 0, rise_cyc = 0;

  aes_spi_slave #(.NK(4), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso4),
    .rx_data(rx_data4), .rx_valid(rx_valid4), .tx_data(tx_data4),
    .tx_load(tx_load4), .tx_pending(tx_pending4)
`ifdef AES_SPI_FRAME_ERR_EN
    , .frame_err(frame_err4)
`endif
  );

  aes_spi_slave #(.NK(8), .SYNC_STAGES(SS)) dut8 (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_data(tx_data8),
    .tx_load(tx_load8), .tx_pending(tx_pending8)
`ifdef AES_SPI_FRAME_ERR_EN
    , .frame_err(frame_err8)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid4) begin
      nvalid4++;
      valid_cyc4 = cyc;
    end
    if (rx_valid8) nvalid8++;
`ifdef AES_SPI_FRAME_ERR_EN
    if (frame_err4) nferr4++;
`endif
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [255:0] mo, input int nbits,
                            output logic [255:0] mi4, output logic [255:0] mi8);
    mi4 = '0;
    mi8 = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[nbits-1-i];
      wait_clk(HALF);
      mi4[nbits-1-i] = miso4;
      mi8[nbits-1-i] = miso8;
      sck = 1'b1;
      rise_cyc = cyc;
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [255:0] mo, input int nbits,
                       output logic [255:0] mi4, output logic [255:0] mi8);
    cs_n = 1'b0;
    wait_clk(HALF);
    clock_bits(mo, nbits, mi4, mi8);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic load4(input logic [127:0] d);
    tx_data4 = d;
    tx_load4 = 1'b1;
    wait_clk(1);
    tx_load4 = 1'b0;
    wait_clk(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    tests++; if (miso4 !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso4); end
    tests++; if (rx_data4 !== '0) begin fails++; $display("FAIL reset_rx_data: got %h want 0", rx_data4); end
    tests++; if (rx_valid4 !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid4); end
    tests++; if (tx_pending4 !== 1'b0) begin fails++; $display("FAIL reset_tx_pending: got %b want 0", tx_pending4); end
    tests++; if (rx_data8 !== '0) begin fails++; $display("FAIL reset_rx_data8: got %h want 0", rx_data8); end
`ifdef AES_SPI_FRAME_ERR_EN
    tests++; if (frame_err4 !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err4); end
`endif
  endtask

  task automatic test_rx_frame();
    logic [255:0] mi4, mi8;
    int v0;
    v0 = nvalid4;
    frame(128'h000102030405060708090a0b0c0d0e0f, 128, mi4, mi8);
    tests++; if (rx_data4 !== 128'h000102030405060708090a0b0c0d0e0f) begin fails++; $display("FAIL rx_data: got %h want 000102030405060708090a0b0c0d0e0f", rx_data4); end
    tests++; if (nvalid4 - v0 != 1) begin fails++; $display("FAIL rx_valid_cycles: got %0d want 1", nvalid4 - v0); end
    tests++; if (valid_cyc4 - rise_cyc != SS + 2) begin fails++; $display("FAIL rx_valid_latency: got %0d want %0d", valid_cyc4 - rise_cyc, SS + 2); end
  endtask

  task automatic test_tx();
    logic [255:0] mi4, mi8;
    load4({16{8'hA5}});
    tests++; if (tx_pending4 !== 1'b1) begin fails++; $display("FAIL tx_pending_set: got %b want 1", tx_pending4); end
    cs_n = 1'b0;
    wait_clk(HALF);
    tests++; if (tx_pending4 !== 1'b0) begin fails++; $display("FAIL tx_pending_clear: got %b want 0", tx_pending4); end
    clock_bits(128'h3c3c3c3c_00ff00ff_12345678_9abcdef0, 128, mi4, mi8);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    tests++; if (mi4[127:0] !== {16{8'hA5}}) begin fails++; $display("FAIL tx_miso: got %h want %h", mi4[127:0], {16{8'hA5}}); end
    tests++; if (rx_data4 !== 128'h3c3c3c3c_00ff00ff_12345678_9abcdef0) begin fails++; $display("FAIL tx_rx_data: got %h want 3c3c3c3c00ff00ff123456789abcdef0", rx_data4); end
    tests++; if (miso4 !== 1'b0) begin fails++; $display("FAIL idle_miso: got %b want 0", miso4); end
    frame(128'h1, 128, mi4, mi8);
    tests++; if (mi4[127:0] !== '0) begin fails++; $display("FAIL tx_empty_miso: got %h want 0", mi4[127:0]); end
    tests++; if (rx_data4 !== 128'h1) begin fails++; $display("FAIL tx_rx_data2: got %h want 1", rx_data4); end
  endtask

  task automatic test_abort();
    logic [255:0] mi4, mi8;
    logic [127:0] r;
    int v0, e0;
    r  = rx_data4;
    v0 = nvalid4;
    e0 = nferr4;
    frame(64'hffff0000_aaaa5555, 64, mi4, mi8);
    tests++; if (rx_data4 !== r) begin fails++; $display("FAIL abort_rx_data: got %h want %h", rx_data4, r); end
    tests++; if (nvalid4 != v0) begin fails++; $display("FAIL abort_rx_valid: got %0d pulses want 0", nvalid4 - v0); end
`ifdef AES_SPI_FRAME_ERR_EN
    tests++; if (nferr4 - e0 != 1) begin fails++; $display("FAIL abort_frame_err: got %0d pulses want 1", nferr4 - e0); end
`endif
  endtask

  task automatic test_overrun();
    logic [255:0] mi4, mi8;
    logic [127:0] x, t;
    int v0, e0;
    x = 128'hdeadbeef_cafef00d_13579bdf_2468ace0;
    t = 128'h01234567_89abcdef_fedcba98_76543211;
    load4(t);
    v0 = nvalid4;
    e0 = nferr4;
    frame({126'h0, x, 2'b10}, 130, mi4, mi8);
    tests++; if (rx_data4 !== x) begin fails++; $display("FAIL overrun_rx_data: got %h want %h", rx_data4, x); end
    tests++; if (nvalid4 - v0 != 1) begin fails++; $display("FAIL overrun_rx_valid: got %0d pulses want 1", nvalid4 - v0); end
    tests++; if (mi4[129:2] !== t) begin fails++; $display("FAIL overrun_miso: got %h want %h", mi4[129:2], t); end
    tests++; if (mi4[1:0] !== 2'b11) begin fails++; $display("FAIL overrun_miso_hold: got %b want 11", mi4[1:0]); end
`ifdef AES_SPI_FRAME_ERR_EN
    tests++; if (nferr4 - e0 != 1) begin fails++; $display("FAIL overrun_frame_err: got %0d pulses want 1", nferr4 - e0); end
`endif
  endtask

  task automatic test_reset_midframe();
    logic [255:0] mi4, mi8;
    int v0, e0;
    v0 = nvalid4;
    e0 = nferr4;
    cs_n = 1'b0;
    wait_clk(HALF);
    clock_bits({128{2'b10}}, 40, mi4, mi8);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    clock_bits({128{2'b10}}, 88, mi4, mi8);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
    tests++; if (rx_data4 !== '0) begin fails++; $display("FAIL midrst_rx_data: got %h want 0", rx_data4); end
    tests++; if (nvalid4 != v0) begin fails++; $display("FAIL midrst_rx_valid: got %0d pulses want 0", nvalid4 - v0); end
`ifdef AES_SPI_FRAME_ERR_EN
    tests++; if (nferr4 != e0) begin fails++; $display("FAIL midrst_frame_err: got %0d pulses want 0", nferr4 - e0); end
`endif
    v0 = nvalid4;
    frame({128{1'b1}}, 128, mi4, mi8);
    tests++; if (rx_data4 !== {128{1'b1}}) begin fails++; $display("FAIL midrst_next_frame: got %h want all ones", rx_data4); end
    tests++; if (nvalid4 - v0 != 1) begin fails++; $display("FAIL midrst_next_valid: got %0d pulses want 1", nvalid4 - v0); end
  endtask

  task automatic test_nk8();
    logic [255:0] mi4, mi8, mo, t;
    int v0;
    mo = 256'h9f3a1c7e_55d20b84_e6017a3c_c4b8f219_0d7e6a53_a1f48c26_3b9e07d5_71c2e8f4;
    t  = 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_603deb10_15ca71be_2b73aef0_857d7781;
    tx_data8 = t;
    tx_load8 = 1'b1;
    wait_clk(1);
    tx_load8 = 1'b0;
    wait_clk(1);
    v0 = nvalid8;
    frame(mo, 256, mi4, mi8);
    tests++; if (rx_data8 !== mo) begin fails++; $display("FAIL nk8_rx_data: got %h want %h", rx_data8, mo); end
    tests++; if (mi8 !== t) begin fails++; $display("FAIL nk8_miso: got %h want %h", mi8, t); end
    tests++; if (nvalid8 - v0 != 1) begin fails++; $display("FAIL nk8_rx_valid: got %0d pulses want 1", nvalid8 - v0); end
  endtask

  initial begin
    test_reset();
    test_rx_frame();
    test_tx();
    test_abort();
    test_overrun();
    test_reset_midframe();
    test_nk8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
